fas_serial_ctrl: RTL
====================

// Module: fas_serial_ctrl
// PURPOSE
//  Sequencer for one 1-bit full adder/subtractor cell (fas). Computes a
//  W-bit add or subtract bit-serially, LSB first, one bit per clock.
//  Loads the operands and clears the carry/borrow flop. Drives the cell for
//  W cycles, then returns sum, carry/borrow-out and a done pulse.
//  Sits between a requesting controller and the shared fas cell.
// PARAMETERS
//  W      8   operand/result width in bits, >=2
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  synchronous active-low reset, sampled on clk
//  start      in   1  request; accepted only in IDLE
//  op_sub     in   1  0 = a+b, 1 = a-b; sampled with start
//  op_a       in   W  operand a; sampled with start
//  op_b       in   W  operand b; sampled with start
//  busy       out  1  high while in RUN
//  done       out  1  one-cycle pulse: result/cout/ovf valid
//  result     out  W  sum or difference; held until the next accepted start
//  cout       out  1  final carry (add) or borrow (sub)
//  ovf        out  1  signed overflow (see CONFIGURATION)
//  fa_a       out  1  to fas.a
//  fa_b       out  1  to fas.b
//  fa_cin     out  1  to fas.cin (carry or borrow in)
//  fa_a_ns    out  1  to fas.a_ns: 1 = add, 0 = subtract (= ~op_sub latched)
//  fa_s       in   1  from fas.s  = a^b^cin
//  fa_cout    in   1  from fas.cout: add = maj(a,b,cin); sub = borrow of a-b-cin
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge) has priority over everything:
//    state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0.
//    Internal shift regs, carry flop and bit count are cleared; fa_* = 0 except fa_a_ns=1.
//  - Reset mid-RUN aborts the operation. No done pulse; the partial result is discarded.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: at an edge with start=1, latch a_sh=op_a, b_sh=op_b,
//    sub=op_sub; clear carry flop and bit count k; go to RUN.
//  - RUN, cycle k=0..W-1, combinational to the cell:
//    fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry, fa_a_ns=~sub.
//  - RUN, at the end of each cycle:
//    res_sh <= {fa_s,res_sh[W-1:1]}; carry <= fa_cout; a_sh,b_sh >>= 1; k++.
//  - RUN, at the end of cycle k=W-1: go to DONE. The k=W-1 values of fa_cin
//    and fa_cout are captured for ovf.
//  - DONE, one cycle: done=1, busy=0. result=res_sh, cout=carry, ovf
//    registered and stable. Then go to IDLE.
//  - Latency: done is high exactly W+1 cycles after the edge that accepted start.
//    Back-to-back: the next start can be accepted in the cycle after DONE.
//  - start in RUN or DONE is ignored; no queueing, no error flag.
//    Operand/op changes after acceptance have no effect.
//  - The carry flop resets to 0 for both ops. Subtract uses borrow
//    semantics (cin/cout are borrows), so no +1 injection is done.
//  - result/cout/ovf change only on the DONE transition or on reset.
//  - Timing: the cell path fa_a..fa_s/fa_cout is at most 30 time units.
//    The clk period must exceed this. fa_s/fa_cout are sampled once per edge.
//  - Width: k counts 0..W-1 in $clog2(W) bits; no wrap beyond W-1.
// CONFIGURATION
//  - Macro FAS_SERIAL_OVF_EN defined:
//    ovf = fa_cin ^ fa_cout at bit W-1, registered into DONE.
//    This is two's-complement overflow for add and sub.
//  - Macro not defined: ovf tied to 0, capture logic omitted; port still present.
// TESTING (W=8, FAS_SERIAL_OVF_EN defined)
//  - Add 0x5A+0x3C -> done at start+9: result=0x96, cout=0, ovf=1.
//  - Sub 0x10-0x20 -> result=0xF0, cout(borrow)=1, ovf=0;
//    fa_a_ns=0 for all 8 RUN cycles.
//  - Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0.
//    Sub 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
//  - start pulsed again in RUN cycle 3 with other operands -> ignored.
//    First result is correct; exactly one done pulse.
//  - rst_n=0 during RUN cycle 4 -> next cycle IDLE, all outputs 0, no done.
//    A new start after release completes normally.
//  - Macro undefined build: the 0x5A+0x3C case gives ovf=0; result and cout unchanged.

Source files
------------

// File: rtl/fas_serial_if.sv
// fas_serial_if: request/response bundle between a controller and fas_serial_ctrl
interface fas_serial_if #(parameter int W = 8);
  logic         start;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  modport master (output start, op_sub, op_a, op_b, input busy, done, result, cout, ovf);
  modport slave (input start, op_sub, op_a, op_b, output busy, done, result, cout, ovf);
endinterface

// File: rtl/fas_serial_ctrl.sv
// fas_serial_ctrl: bit-serial W-bit add/sub sequencer for one fas cell; FAS_SERIAL_OVF_EN enables ovf capture
module fas_serial_ctrl #(parameter int W = 8) (
  input  logic        clk,
  input  logic        rst_n,
  fas_serial_if.slave bus,
  output logic        fa_a,
  output logic        fa_b,
  output logic        fa_cin,
  output logic        fa_a_ns,
  input  logic        fa_s,
  input  logic        fa_cout
);
  localparam int KW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [KW-1:0] k_q, k_d;
  logic sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
  logic run, last, go;
  always_comb begin
    run      = state_q == RUN;
    last     = run && k_q == KW'(W - 1);
    go       = state_q == IDLE && bus.start;
    state_d  = go ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
    a_d      = go ? bus.op_a : run ? a_q >> 1 : a_q;
    b_d      = go ? bus.op_b : run ? b_q >> 1 : b_q;
    sub_d    = go ? bus.op_sub : sub_q;
    carry_d  = go ? 1'b0 : run ? fa_cout : carry_q;
    k_d      = go ? '0 : run && !last ? k_q + 1'b1 : k_q;
    res_d    = run ? {fa_s, res_q[W-1:1]} : res_q;
    result_d = last ? res_d : result_q;
    cout_d   = last ? fa_cout : cout_q;
    fa_a     = run & a_q[0];
    fa_b     = run & b_q[0];
    fa_cin   = run & carry_q;
    fa_a_ns  = ~sub_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      k_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      result_q <= result_d;
      k_q      <= k_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end
`ifdef FAS_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = last ? fa_cin ^ fa_cout : ovf_q;
  always_ff @(posedge clk) ovf_q <= rst_n ? ovf_d : 1'b0;
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
  assign bus.busy   = run;
  assign bus.done   = state_q == DONE;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
endmodule
